// File: rtl/dmu_pkg.sv
// -----------------------------------------------------------------------------
// dmu_pkg
// Shared definitions for the data memory unit:
//   - funct3_e : load/store size and sign encodings carried on Funct3
//   - state_e  : request FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   - lane_extend() : picks the addressed byte/halfword out of a 32-bit word,
//                     shifts it to bit 0 and sign- or zero-extends it
// -----------------------------------------------------------------------------
package dmu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,   // LB / SB
        F3_H  = 3'b001,   // LH / SH
        F3_W  = 3'b010,   // LW / SW
        F3_BU = 3'b100,   // LBU
        F3_HU = 3'b101    // LHU
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Halfwords use only off[1]; the low offset bit is dropped, which gives the
    // forced alignment when misaligned accesses are not trapped.
    function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'b0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmu_mem_array.sv
// -----------------------------------------------------------------------------
// dmu_mem_array
// Byte-lane-enabled synchronous single-port RAM, DEPTH words of WIDTH bits.
// No reset: contents survive a unit reset.
// Ports:
//   clk   : clock
//   en    : port enable; a read of addr is registered into rdata when set
//   be    : per-byte write enables (bit i writes wdata[8i+7:8i])
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (old contents on a same-cycle write)
// -----------------------------------------------------------------------------
module dmu_mem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [WIDTH/8-1:0]       be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < WIDTH/8; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
// Load/store unit in front of a word-organised data RAM. One request at a time:
// accepted in IDLE, memory touched in ACCESS, result registered in RESP, so
// dmu_valid pulses in the cycle after the second edge following acceptance.
// The byte/half lane logic assumes WIDTH = 32 (four byte lanes).
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   read_en      : load request
//   write_en     : store request
//   Funct3       : access size/sign (see dmu_pkg::funct3_e)
//   Mem_addr_out : byte address
//   RS2_data_out : store data (low bytes used)
//   dmu_out_data : last successful load result, extended to WIDTH
//   dmu_ready    : high in IDLE, request can be accepted
//   dmu_valid    : one-cycle completion pulse
//   dmu_err      : with dmu_valid, the request was rejected
//
// Build option: define DMU_MISALIGN_CHK_EN to reject misaligned halfword/word
// accesses; otherwise the low address bits are ignored for those sizes.
// -----------------------------------------------------------------------------
module data_mem_unit
    import dmu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_en,
    input  logic             write_en,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] Mem_addr_out,
    input  logic [WIDTH-1:0] RS2_data_out,
    output logic [WIDTH-1:0] dmu_out_data,
    output logic             dmu_ready,
    output logic             dmu_valid,
    output logic             dmu_err
);

    localparam int AW = $clog2(DEPTH);

    state_e            state;
    logic              accept;
    logic              req_err;

    // Captured request
    logic [AW+1:0]     addr_p0;
    logic [2:0]        f3_p0;
    logic [WIDTH-1:0]  wdata_p0;
    logic              load_p0;
    logic              store_p0;
    logic              err_p0;

    logic [3:0]        lane_be;
    logic [WIDTH-1:0]  lane_wdata;
    logic [3:0]        mem_be;
    logic              mem_en;
    logic [WIDTH-1:0]  mem_rdata;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^Mem_addr_out[WIDTH-1:AW+2];

    assign dmu_ready = (state == ST_IDLE);
    assign accept    = dmu_ready && (read_en || write_en);

    // Request legality, evaluated on the inputs at the accepting edge
    always_comb begin
        req_err = 1'b0;
        if (read_en && write_en) begin
            req_err = 1'b1;
        end else if (write_en) begin
            case (Funct3)
                F3_B, F3_H, F3_W: req_err = 1'b0;
                default:          req_err = 1'b1;
            endcase
        end else begin
            case (Funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: req_err = 1'b0;
                default:                        req_err = 1'b1;
            endcase
        end
`ifdef DMU_MISALIGN_CHK_EN
        if ((Funct3[1:0] == 2'b01) && Mem_addr_out[0]) begin
            req_err = 1'b1;
        end
        if ((Funct3 == F3_W) && (Mem_addr_out[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
`endif
    end

    // ---- stage p0: request capture (data, no reset) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= Mem_addr_out[AW+1:0];
            f3_p0    <= Funct3;
            wdata_p0 <= RS2_data_out;
        end
    end

    // Store lanes: data is replicated across lanes so the enable alone picks
    // the destination byte/half.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_p0;
        case (f3_p0)
            F3_B: begin
                lane_be    = 4'b0001 << addr_p0[1:0];
                lane_wdata = {4{wdata_p0[7:0]}};
            end
            F3_H: begin
                lane_be    = addr_p0[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_p0[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_p0;
            end
        endcase
    end

    // ---- stage ACCESS: memory read / byte-enabled write ----
    assign mem_en = (state == ST_ACCESS);
    assign mem_be = (mem_en && store_p0 && !err_p0) ? lane_be : 4'b0000;

    dmu_mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .be    (mem_be),
        .addr  (addr_p0[AW+1:2]),
        .wdata (lane_wdata),
        .rdata (mem_rdata)
    );

    // ---- stage RESP: control FSM and result register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            load_p0      <= 1'b0;
            store_p0     <= 1'b0;
            err_p0       <= 1'b0;
            dmu_valid    <= 1'b0;
            dmu_err      <= 1'b0;
            dmu_out_data <= '0;
        end else begin
            dmu_valid <= 1'b0;
            dmu_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        load_p0  <= read_en && !write_en;
                        store_p0 <= write_en && !read_en;
                        err_p0   <= req_err;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    dmu_valid <= 1'b1;
                    dmu_err   <= err_p0;
                    if (load_p0 && !err_p0) begin
                        dmu_out_data <= lane_extend(mem_rdata, addr_p0[1:0], f3_p0);
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter WIDTH, default 32: data and address width.
REQ-002 Parameter DEPTH, default 256: memory size in WIDTH-bit words; power of two.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 read_en  in  1  load request.
REQ-006 write_en  in  1  store request.
REQ-007 Funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 Mem_addr_out  in  WIDTH  byte address from the ALU.
REQ-009 RS2_data_out  in  WIDTH  store data, taken from its low bytes.
REQ-010 dmu_out_data  out  WIDTH  load result, extended to WIDTH.
REQ-011 dmu_ready  out  1  block can accept a request this cycle.
REQ-012 dmu_valid  out  1  one-cycle pulse marking access completion.
REQ-013 dmu_err  out  1  qualifies dmu_valid; the access was rejected.

Function
REQ-014 Request accepted on a rising edge where dmu_ready=1 and (read_en or write_en)=1; Funct3, address and store data are captured at that edge.
REQ-015 FSM states IDLE -> ACCESS -> RESP -> IDLE; dmu_ready=1 only in IDLE; ACCESS and RESP each last exactly one cycle.
REQ-016 Latency: request accepted at edge N -> dmu_valid=1 for the cycle after edge N+2; next request may be accepted at edge N+3.
REQ-017 Word index = address[log2(DEPTH)+1:2]; higher address bits are ignored (wrap-around).
REQ-018 Store: byte-enabled write in ACCESS; SB writes lane address[1:0], SH writes lanes address[1]*2..+1, SW writes all four lanes; other bytes are unchanged.
REQ-019 Load: word read in ACCESS; in RESP the selected byte/half is shifted to bit 0, sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-020 dmu_out_data holds its last load value until the next successful load; stores and errors leave it unchanged.
REQ-021 read_en=1 and write_en=1 together -> accepted, no memory change, dmu_err=1 with dmu_valid.
REQ-022 Illegal Funct3 (011, 110, 111, or 100/101 on a store) -> no memory change, dmu_err=1 with dmu_valid.
REQ-023 Requests presented while dmu_ready=0 are ignored and are not queued.
REQ-024 dmu_err=0 whenever dmu_valid=0.

Reset
REQ-025 rst=0 -> state IDLE, dmu_ready=1, dmu_valid=0, dmu_err=0, dmu_out_data=0, all asynchronously.
REQ-026 Reset mid-access abandons the access with no valid pulse; a store already committed in ACCESS remains; memory contents are never cleared by reset.

Configuration
REQ-027 Macro DMU_MISALIGN_CHK_EN defined: a halfword access with address[0]=1 or a word access with address[1:0]!=0 -> no memory change, dmu_err=1 with dmu_valid.
REQ-028 Macro undefined: the misaligned low address bits are ignored (halfword is forced to address[1], word to address[1:0]=0) and no error is raised.

Structure
REQ-029 Shared package dmu_pkg holds the Funct3 encodings as a typedef enum, the FSM state enum, and the lane-extract/extend function.
REQ-030 One sub-module, dmu_mem_array: byte-lane-enabled synchronous single-port RAM of DEPTH x WIDTH with no reset.

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10 -> dmu_out_data=0xDEADBEEF, dmu_err=0, dmu_valid exactly 3 cycles after each accept.
REQ-032 After REQ-031: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-033 SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF; LW @(0x10 + 4*DEPTH) -> the same value (wrap-around).
REQ-034 read_en=write_en=1 @0x10 -> dmu_err=1 and memory unchanged; Funct3=011 -> dmu_err=1.
REQ-035 LW @0x12 -> dmu_err=1 with DMU_MISALIGN_CHK_EN defined; returns word @0x10 with dmu_err=0 without it.
REQ-036 Assert rst=0 during ACCESS of an LW -> no dmu_valid pulse, dmu_ready=1 immediately, following LW completes normally.
